// File: rtl/sobel_edge_detector_if.sv
// Pixel-in / edge-out bundle for the Sobel stage.
// The master side is the pixel source; the slave side is the detector.
interface sobel_edge_detector_if;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic       sof;
  logic [7:0] edge_out;
  logic       edge_valid;
  logic       edge_last;

  modport master (
    output pixel_in, pixel_valid, sof,
    input  edge_out, edge_valid, edge_last
  );

  modport slave (
    input  pixel_in, pixel_valid, sof,
    output edge_out, edge_valid, edge_last
  );
endinterface

// File: rtl/sobel_edge_detector.sv
// 3x3 Sobel edge detector on a raster pixel stream.
// Three registered stages: window capture, gradients, magnitude/output.
module sobel_edge_detector #(
  parameter int unsigned WIDTH     = 256,
  parameter int unsigned HEIGHT    = 256,
  parameter bit          BINARY    = 1'b0,
  parameter int unsigned THRESHOLD = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  sobel_edge_detector_if.slave  bus
);

  localparam int unsigned CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [CW-1:0] col_q, col_d, eff_col;
  logic [RW-1:0] row_q, row_d, eff_row;
  logic          accept, at_last_col, at_last_row;
  logic [7:0]    top_rd, mid_rd;

  logic [2:0][2:0][7:0] win_q, win_d;
  logic          v1_q, v1_d, ok1_q, ok1_d, last1_q, last1_d;

  logic signed [10:0] gx_q, gx_d, gy_q, gy_d;
  logic [10:0]   gx_pos, gx_neg, gy_pos, gy_neg;
  logic          v2_q, v2_d, ok2_q, ok2_d, last2_q, last2_d;

  logic [10:0]   ax, ay;
  logic [11:0]   mag;
  logic [7:0]    sat, val;
  logic [7:0]    out_q, out_d;
  logic          valid_q, valid_d, last_q, last_d;

  // Line buffers hold rows row-2 and row-1; deliberately left unreset.
  logic [7:0]    lb0_mem [WIDTH];
  logic [7:0]    lb1_mem [WIDTH];

  assign accept      = bus.pixel_valid;
  assign eff_col     = bus.sof ? '0 : col_q;
  assign eff_row     = bus.sof ? '0 : row_q;
  assign at_last_col = (eff_col == CW'(WIDTH - 1));
  assign at_last_row = (eff_row == RW'(HEIGHT - 1));
  assign top_rd      = lb0_mem[eff_col];
  assign mid_rd      = lb1_mem[eff_col];

  // Position counters and window capture.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    v1_d    = accept;
    ok1_d   = 1'b0;
    last1_d = 1'b0;
    if (accept) begin
      if (at_last_col) begin
        col_d = '0;
        row_d = at_last_row ? '0 : eff_row + RW'(1);
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = top_rd;
      win_d[1][2] = mid_rd;
      win_d[2][2] = bus.pixel_in;
      ok1_d       = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
      last1_d     = at_last_col && at_last_row;
    end
  end

  // Gradients: all terms are non-negative sums of at most 4*255, so 11 bits signed is exact.
  always_comb begin
    gx_pos  = 11'(win_q[0][2]) + (11'(win_q[1][2]) << 1) + 11'(win_q[2][2]);
    gx_neg  = 11'(win_q[0][0]) + (11'(win_q[1][0]) << 1) + 11'(win_q[2][0]);
    gy_pos  = 11'(win_q[2][0]) + (11'(win_q[2][1]) << 1) + 11'(win_q[2][2]);
    gy_neg  = 11'(win_q[0][0]) + (11'(win_q[0][1]) << 1) + 11'(win_q[0][2]);
    gx_d    = $signed(gx_pos - gx_neg);
    gy_d    = $signed(gy_pos - gy_neg);
    v2_d    = v1_q;
    ok2_d   = ok1_q;
    last2_d = last1_q;
  end

  // Magnitude, saturation, optional threshold and border masking.
  always_comb begin
    ax      = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
    ay      = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
    mag     = 12'(ax) + 12'(ay);
    sat     = (mag > 12'd255) ? 8'hFF : mag[7:0];
    if (BINARY) val = (sat >= 8'(THRESHOLD)) ? 8'hFF : 8'h00;
    else        val = sat;
    out_d   = (v2_q && ok2_q) ? val : 8'h00;
    valid_d = v2_q;
    last_d  = v2_q && last2_q;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_mem[eff_col] <= mid_rd;
      lb1_mem[eff_col] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      v1_q    <= 1'b0;
      ok1_q   <= 1'b0;
      last1_q <= 1'b0;
      gx_q    <= '0;
      gy_q    <= '0;
      v2_q    <= 1'b0;
      ok2_q   <= 1'b0;
      last2_q <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      v1_q    <= v1_d;
      ok1_q   <= ok1_d;
      last1_q <= last1_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      v2_q    <= v2_d;
      ok2_q   <= ok2_d;
      last2_q <= last2_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.edge_out   = out_q;
  assign bus.edge_valid = valid_q;
  assign bus.edge_last  = last_q;

endmodule
